// File: rtl/ddr_rd_arb.sv
// ddr_rd_arb: two-master AXI4 read-channel arbiter (CPU, display fetcher) in front of one DDR AXI port.
// One read burst is outstanding at a time. Grants go round-robin, and a grant is held until the burst's last R beat.
// Ports:
//   clk, rstn                   core clock and asynchronous active-low reset
//   s0_ar*/s0_r*, s1_ar*/s1_r*  AXI read address/data channels of master 0 (CPU) and master 1 (display)
//   m_ar*/m_r*                  AXI read address/data channels towards memory (AR fields registered)
//   o_grant                     one-hot current grant, 00 when idle
//   o_len_err                   sticky flag: beat count of a burst did not match arlen+1
// Build option: define DDR_RD_ARB_URGENT_EN to add input s1_urgent, which lets master 1 win in IDLE regardless of the RR pointer.
module ddr_rd_arb #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [ID_W-1:0]   s0_rid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [ID_W-1:0]   s1_rid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,
`ifdef DDR_RD_ARB_URGENT_EN
    input  logic              s1_urgent,
`endif
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [1:0]        o_grant,
    output logic              o_len_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nxt;
    logic rr;
    logic [7:0] cnt;
    logic urgent, pick1, take, r_hs, sel0, sel1;
`ifdef DDR_RD_ARB_URGENT_EN
    assign urgent = s1_urgent;
`else
    assign urgent = 1'b0;
`endif
    always_comb begin
        // rr high means the pointer favours master 1
        pick1      = s1_arvalid & (~s0_arvalid | rr | urgent);
        take       = (state == IDLE) & (s0_arvalid | s1_arvalid);
        s0_arready = rstn & take & ~pick1;
        s1_arready = rstn & take & pick1;
        sel0       = (state == DATA) & o_grant[0];
        sel1       = (state == DATA) & o_grant[1];
        m_rready   = (sel0 & s0_rready) | (sel1 & s1_rready);
        r_hs       = m_rvalid & m_rready;
        s0_rvalid  = sel0 & m_rvalid;
        s0_rid     = sel0 ? m_rid : '0;
        s0_rdata   = sel0 ? m_rdata : '0;
        s0_rresp   = sel0 ? m_rresp : '0;
        s0_rlast   = sel0 & m_rlast;
        s1_rvalid  = sel1 & m_rvalid;
        s1_rid     = sel1 ? m_rid : '0;
        s1_rdata   = sel1 ? m_rdata : '0;
        s1_rresp   = sel1 ? m_rresp : '0;
        s1_rlast   = sel1 & m_rlast;
        state_nxt  = state;
        state_nxt  = (state == IDLE && take) ? ADDR :
                     (state == ADDR && m_arready) ? DATA :
                     (state == DATA && r_hs && m_rlast) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_arid    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
            m_arvalid <= 1'b0;
            o_grant   <= 2'b00;
            o_len_err <= 1'b0;
            rr        <= 1'b0;
            cnt       <= '0;
        end else begin
            m_arvalid <= (state_nxt == ADDR);
            if (take) begin
                m_arid    <= pick1 ? s1_arid : s0_arid;
                m_araddr  <= pick1 ? s1_araddr : s0_araddr;
                m_arlen   <= pick1 ? s1_arlen : s0_arlen;
                m_arsize  <= pick1 ? s1_arsize : s0_arsize;
                m_arburst <= pick1 ? s1_arburst : s0_arburst;
                o_grant   <= pick1 ? 2'b10 : 2'b01;
                cnt       <= pick1 ? s1_arlen : s0_arlen;
            end
            if (r_hs) begin
                cnt <= cnt - 8'd1;
                // rlast must coincide exactly with the beat where the counter is at zero
                if (m_rlast != (cnt == 8'd0)) o_len_err <= 1'b1;
                if (m_rlast) begin
                    o_grant <= 2'b00;
                    rr      <= o_grant[0];
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr_rd_arb.sv
// tb_ddr_rd_arb: self-checking bench for ddr_rd_arb (vector table, corner sequences, randomized bursts vs model).
module tb_ddr_rd_arb;
    localparam int ID_W = 6, ADDR_W = 32, DATA_W = 64;
`ifdef DDR_RD_ARB_URGENT_EN
    localparam bit URG = 1'b1;
`else
    localparam bit URG = 1'b0;
`endif
    logic clk = 1'b0, rstn = 1'b0;
    logic [ID_W-1:0] s0_arid = '0, s1_arid = '0, s0_rid, s1_rid, m_arid, m_rid = '0;
    logic [ADDR_W-1:0] s0_araddr = '0, s1_araddr = '0, m_araddr;
    logic [7:0] s0_arlen = '0, s1_arlen = '0, m_arlen;
    logic [2:0] s0_arsize = '0, s1_arsize = '0, m_arsize;
    logic [1:0] s0_arburst = '0, s1_arburst = '0, m_arburst;
    logic s0_arvalid = 0, s1_arvalid = 0, s0_arready, s1_arready;
    logic [DATA_W-1:0] s0_rdata, s1_rdata, m_rdata = '0;
    logic [1:0] s0_rresp, s1_rresp, m_rresp = '0, o_grant;
    logic s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready = 0, s1_rready = 0;
    logic m_arvalid, m_arready = 0, m_rlast = 0, m_rvalid = 0, m_rready, o_len_err;
    logic s1_urgent = 0;
    int checks = 0, failures = 0;
    bit exp_rr = 0, exp_err = 0;

    ddr_rd_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
`ifdef DDR_RD_ARB_URGENT_EN
        .s1_urgent(s1_urgent),
`endif
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .o_grant(o_grant), .o_len_err(o_len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 0;
        m_rvalid = 0; m_rlast = 0; m_arready = 0;
        s1_arvalid = 0; s0_rready = 1; s1_rready = 1;
        s0_arvalid = 1;
        #1;
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_len_err", o_len_err, 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_s0_arready", s0_arready, 0);
        chk("rst_s0_rvalid", s0_rvalid, 0);
        step;
        s0_arvalid = 0;
        rstn = 1;
        exp_rr = 0;
        exp_err = 0;
    endtask

    // win: 0/1 = expected winner, 2 = no request; lastb = index of the beat carrying rlast
    task automatic run_burst(input bit v0, input bit v1, input logic [7:0] len, input int win,
                             input int ardly, input int lastb, input bit bp);
        logic [ADDR_W-1:0] a0 = $urandom, a1 = $urandom;
        logic [ID_W-1:0] id0 = ID_W'($urandom), id1 = ID_W'($urandom);
        logic [ID_W-1:0] idw;
        s0_arid = id0; s0_araddr = a0; s0_arlen = len; s0_arsize = 3; s0_arburst = 1;
        s1_arid = id1; s1_araddr = a1; s1_arlen = len; s1_arsize = 2; s1_arburst = 1;
        s0_arvalid = v0; s1_arvalid = v1;
        idw = (win == 0) ? id0 : id1;
        #1;
        chk("arready0", s0_arready, win == 0);
        chk("arready1", s1_arready, win == 1);
        step;
        s0_arvalid = 0; s1_arvalid = 0;
        if (win == 2) begin
            chk("idle_grant", o_grant, 0);
            chk("idle_m_arvalid", m_arvalid, 0);
            return;
        end
        chk("grant", o_grant, (win == 0) ? 2'b01 : 2'b10);
        chk("m_arvalid", m_arvalid, 1);
        chk("m_araddr", m_araddr, (win == 0) ? a0 : a1);
        chk("m_arlen", m_arlen, len);
        chk("m_arid", m_arid, idw);
        chk("m_arsize", m_arsize, (win == 0) ? 3 : 2);
        m_rvalid = 1;
        for (int i = 0; i < ardly; i++) begin
            #1;
            chk("addr_stall_rready", m_rready, 0);
            chk("addr_s_rvalid", s0_rvalid | s1_rvalid, 0);
            step;
            chk("addr_hold", m_arvalid, 1);
        end
        m_rvalid = 0;
        m_arready = 1;
        step;
        m_arready = 0;
        chk("ar_drop", m_arvalid, 0);
        for (int b = 0; b <= lastb;) begin
            logic rdy;
            logic [DATA_W-1:0] d;
            rdy = bp ? ($urandom_range(3) != 0) : 1'b1;
            d = {$urandom, $urandom};
            m_rvalid = 1; m_rdata = d; m_rid = idw; m_rresp = 2'($urandom); m_rlast = (b == lastb);
            s0_rready = (win == 0) ? rdy : 1'($urandom);
            s1_rready = (win == 1) ? rdy : 1'($urandom);
            #1;
            chk("m_rready", m_rready, rdy);
            chk("win_rvalid", (win == 0) ? s0_rvalid : s1_rvalid, 1);
            chk("win_rdata", (win == 0) ? s0_rdata : s1_rdata, d);
            chk("win_rid", (win == 0) ? s0_rid : s1_rid, idw);
            chk("win_rlast", (win == 0) ? s0_rlast : s1_rlast, b == lastb);
            chk("lose_rvalid", (win == 0) ? s1_rvalid : s0_rvalid, 0);
            chk("lose_rdata", (win == 0) ? s1_rdata : s0_rdata, 0);
            step;
            if (rdy) b++;
        end
        m_rvalid = 0; m_rlast = 0;
        if (lastb != int'(len)) exp_err = 1;
        exp_rr = (win == 0);
        chk("grant_clear", o_grant, 0);
        chk("len_err", o_len_err, exp_err);
    endtask

    typedef struct {
        bit v0;
        bit v1;
        logic [7:0] len;
        int lastb;
        int win;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int w;
        tbl[0] = '{1, 0, 8'd2, 2, 0};
        tbl[1] = '{1, 1, 8'd1, 1, 1};
        tbl[2] = '{1, 1, 8'd0, 0, 0};
        tbl[3] = '{1, 0, 8'd3, 3, 0};
        tbl[4] = '{1, 1, 8'd2, 2, 1};
        tbl[5] = '{0, 1, 8'd1, 1, 1};
        tbl[6] = '{1, 1, 8'd1, 1, 0};
        tbl[7] = '{0, 0, 8'd1, 1, 2};
        tbl[8] = '{1, 1, 8'd3, 1, 1};
        tbl[9] = '{1, 0, 8'd1, 1, 0};
        step;
        do_reset;
        // urgent request overrides a pointer that favours master 0 when the option is built in
        s1_urgent = 1;
        run_burst(1, 1, 8'd1, URG ? 1 : 0, 0, 1, 0);
        s1_urgent = 0;
        do_reset;
        run_burst(1, 0, 8'd3, 0, 2, 3, 0);
        do_reset;
        foreach (tbl[i]) run_burst(tbl[i].v0, tbl[i].v1, tbl[i].len, tbl[i].win, 1, tbl[i].lastb, 0);
        chk("len_err_sticky", o_len_err, 1);
        do_reset;
        // both masters request continuously: grants alternate, next AR accepted right after rlast
        s0_araddr = 32'h1000; s1_araddr = 32'h2000; s0_arlen = 1; s1_arlen = 1;
        s0_arvalid = 1; s1_arvalid = 1;
        w = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("alt_arready0", s0_arready, w == 0);
            chk("alt_arready1", s1_arready, w == 1);
            step;
            chk("alt_grant", o_grant, (w == 0) ? 2'b01 : 2'b10);
            chk("alt_araddr", m_araddr, (w == 0) ? 32'h1000 : 32'h2000);
            m_arready = 1;
            step;
            m_arready = 0;
            for (int b = 0; b < 2; b++) begin
                m_rvalid = 1; m_rlast = (b == 1); m_rdata = 64'(k * 16 + b);
                #1;
                chk("alt_rvalid", (w == 0) ? s0_rvalid : s1_rvalid, 1);
                chk("alt_rdata", (w == 0) ? s0_rdata : s1_rdata, 64'(k * 16 + b));
                step;
            end
            m_rvalid = 0; m_rlast = 0;
            if (k == 5) begin
                s0_arvalid = 0; s1_arvalid = 0;
            end
            w = 1 - w;
        end
        exp_rr = (w == 1);
        chk("alt_len_err", o_len_err, 0);
        // asynchronous reset in the middle of an 8-beat burst
        s0_arlen = 7; s0_arvalid = 1;
        step;
        s0_arvalid = 0;
        m_arready = 1;
        step;
        m_arready = 0;
        m_rvalid = 1; m_rlast = 0;
        step;
        #1;
        chk("mid_rvalid_before", s0_rvalid, 1);
        rstn = 0;
        #1;
        chk("mid_rst_arvalid", m_arvalid, 0);
        chk("mid_rst_grant", o_grant, 0);
        chk("mid_rst_rvalid", s0_rvalid | s1_rvalid, 0);
        chk("mid_rst_rready", m_rready, 0);
        do_reset;
        run_burst(0, 1, 8'd2, 1, 1, 2, 0);
        // randomized bursts against the rule-level model
        for (int n = 0; n < 40; n++) begin
            logic [1:0] v;
            logic [7:0] len;
            int lb, wn;
            v = 2'($urandom_range(1, 3));
            len = 8'($urandom_range(0, 7));
            lb = ($urandom_range(7) == 0) ? int'($urandom_range(0, 8)) : int'(len);
            s1_urgent = 1'($urandom);
            wn = (v[0] & v[1]) ? (exp_rr ? 1 : 0) : (v[1] ? 1 : 0);
            if (URG && v[1] && s1_urgent) wn = 1;
            run_burst(v[0], v[1], len, wn, $urandom_range(0, 3), lb, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddr_rd_arb.md
Name: ddr_rd_arb

Overview:
- Two-master AXI4 read-channel arbiter in front of the single DDR2 AXI port (CPU clock domain, ahead of the AXI CDC).
- Master 0 is the CPU; master 1 is the display framebuffer fetcher.
- Grants one read burst at a time, round-robin, holding the grant until the burst's last R beat.
- Write channels bypass this block and stay CPU-only.

Parameters:
- ID_W, 6, AXI ID width for masters and slave.
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI data width.

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
sN_arid  in  ID_W  master N read ID (N = 0, 1; one set per master)
sN_araddr  in  ADDR_W  master N read address
sN_arlen  in  8  master N burst length minus 1
sN_arsize  in  3  master N beat size
sN_arburst  in  2  master N burst type
sN_arvalid  in  1  master N AR valid
sN_arready  out  1  master N AR ready
sN_rid  out  ID_W  read ID routed to master N
sN_rdata  out  DATA_W  read data routed to master N
sN_rresp  out  2  read response routed to master N
sN_rlast  out  1  last beat routed to master N
sN_rvalid  out  1  read data valid to master N
sN_rready  in  1  master N read data ready
m_arid, m_araddr, m_arlen, m_arsize, m_arburst  out  as above  registered AR fields to memory
m_arvalid  out  1  AR valid to memory
m_arready  in  1  AR ready from memory
m_rid, m_rdata, m_rresp, m_rlast, m_rvalid  in  as above  R channel from memory
m_rready  out  1  R ready to memory
o_grant  out  2  one-hot current grant; 00 when idle
o_len_err  out  1  sticky: burst beat count mismatched arlen+1

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; m_arvalid=0; all m_ar* fields=0; o_grant=00; o_len_err=0; RR pointer favours master 0; beat counter=0. All sN_arready and sN_rvalid are 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Winner selection: if only one sN_arvalid is high, that master wins. If both are high, the master the RR pointer favours wins.
  - Winner's sN_arready is driven combinationally high in the same cycle. The loser's arready stays 0.
  - At that clock edge: capture the winner's AR fields into m_ar*, set o_grant, load beat counter = arlen, go to ADDR.
- ADDR:
  - m_arvalid=1; fields stay stable.
  - On m_arready: drop m_arvalid, go to DATA.
  - Minimum latency is 1 cycle from sN_arvalid&arready to m_arvalid.
- DATA:
  - Granted master: sN_rvalid=m_rvalid and sN_r*=m_r* (combinational); m_rready=sN_rready of the granted master.
  - Non-granted master: rvalid=0, r* fields=0.
  - Each R handshake decrements the beat counter.
  - On a handshake with m_rlast=1: return to IDLE, clear o_grant, set the RR pointer to favour the other master.
  - Length check: rlast on a beat with counter≠0, or counter reaching 0 without rlast, sets o_len_err. The FSM still exits only on rlast.
- No new AR is accepted before the previous burst completes (one outstanding transaction). The AR-to-IDLE path therefore never overlaps DATA.
- Back-to-back: from rlast in cycle N, IDLE in N+1 may accept immediately. Sustained alternation when both masters request continuously.
- R beats arriving with the FSM in IDLE or ADDR: m_rready=0 (stall); never dropped.
- A master dropping arvalid while not granted: legal; no state change.
- o_len_err clears only on reset.

Optional Feature:
- Macro DDR_RD_ARB_URGENT_EN adds input port s1_urgent (1 bit).
- Defined: in IDLE, if s1_arvalid&s1_urgent, master 1 wins regardless of the RR pointer. The RR pointer is still updated as normal. An in-progress burst is never pre-empted.
- Not defined: the port is absent and arbitration is pure round-robin.

Test Plan:
- Single master 0 read, arlen=3, m_arready after 2 cycles, 4 R beats with rlast on the 4th -> s0 receives 4 beats with matching rid/rdata, s1_rvalid stays 0, o_grant 01 then 00, o_len_err=0.
- Both masters assert arvalid in the same cycle after reset -> master 0 granted first. Master 1 is granted in the cycle after master 0's rlast. m_araddr shows s0 then s1 addresses.
- Continuous requests from both masters over 6 bursts -> grants strictly alternate 0,1,0,1,0,1.
- Memory returns rlast on beat 2 of an arlen=3 burst -> o_len_err=1 and stays set. FSM returns to IDLE after that beat.
- rstn pulled low mid-DATA (beat 2 of 8) -> m_arvalid=0, o_grant=00, all sN_rvalid=0 immediately. After release, a new s1 request is accepted normally.
- With DDR_RD_ARB_URGENT_EN: RR pointer favours master 0, both masters request, s1_urgent=1 -> master 1 granted first. With the macro undefined, the same stimulus grants master 0.
